riscv_imem_resp: RTL and testbench
==================================

# riscv_imem_resp

Instruction-memory responder for the RISC-V fetch path. It answers the fetch stage's per-cycle PC requests with 32-bit instruction words from an internal word-addressed array after a configurable number of wait states. While a request is outstanding it drives `bubble` back to the fetch stage, which freezes the PC. A side load port fills the array.

## Interface
- `DEPTH`, 256: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1.
- `WAIT`, 0: wait states per fetch, 0..7.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in 1: fetch stage presents a valid `pc` this cycle.
- `pc` in 32: byte address of the requested instruction.
- `flush` in 1: abort the in-flight request; no response is produced.
- `ld_en` in 1: write `ld_data` to word `ld_addr` at this edge.
- `ld_addr` in 32: word index; writes with index >= DEPTH are ignored.
- `ld_data` in 32: word to load.
- `bubble` out 1: combinational stall to the fetch stage; the PC must hold.
- `instr` out 32: registered instruction word.
- `instr_valid` out 1: registered; `instr` is valid this cycle.
- `fault` out 1: registered; qualifies `instr_valid` to mark a misaligned or out-of-range fetch.

## Operation
- States: IDLE, WAITING. 3-bit wait counter `cnt`.
- Reset values: state IDLE, `cnt`=0, `instr`=32'h00000013 (NOP), `instr_valid`=0, `fault`=0.
- Array contents are not reset.
- `bubble` is 0 whenever `rst` is low.
- A request is bad if `pc[1:0]`!=0 or `pc[31:2]`>=DEPTH.
- IDLE with `req`=1 and `flush`=0 (accept):
  - bad request: next cycle `instr`=NOP, `instr_valid`=1, `fault`=1; no wait states regardless of WAIT; `bubble`=0.
  - WAIT=0: read array at `pc[31:2]`; next cycle `instr`=word, `instr_valid`=1, `fault`=0; `bubble`=0.
  - WAIT>0: `bubble`=1; capture `pc`; `cnt`<=WAIT-1; go to WAITING.
- WAITING:
  - `bubble`=(`cnt`!=0); `cnt` decrements each cycle.
  - When `cnt`==0: read the array at the captured pc, present the response the next cycle, return to IDLE.
  - `req` and `pc` are ignored while WAITING.
- `instr_valid` and `fault` are single-cycle pulses. `instr` keeps its last value when `instr_valid`=0.
- `flush`=1:
  - In IDLE: no request is accepted and `bubble`=0.
  - In WAITING: go to IDLE, `bubble`=0 that cycle, and no response is emitted.
  - `flush` has priority over `req`.
- Load/read collision at the same edge and same word: the read returns the OLD word; the new word is visible to the next fetch.
- Async reset mid-WAITING: return to IDLE immediately; the pending response is dropped.

## Timing
- Request seen in cycle c0, WAIT=W>0, no flush:
  - `bubble`=1 in cycles c0 .. c0+W-1.
  - `bubble`=0 in cycle c0+W, so the fetch stage advances at the end of c0+W.
  - `instr_valid`=1 in cycle c0+W+1.
- Latency is W+1 cycles from request to data.
- Throughput is one fetch per W+1 cycles; the next request is accepted in c0+W+1, the same cycle the response appears.
- WAIT=0: one fetch per cycle and `bubble` stays 0; data is returned one cycle after the request.
- The fetch stage uses `bubble` in the same cycle, so its path from `req`/state to `bubble` is combinational only.

## Test plan
- WAIT=0; words 0..3 loaded with 0x11,0x22,0x33,0x44; `req`=1 with pc 0,4,8,12 on consecutive cycles -> `instr_valid`=1 on 4 consecutive cycles with 0x11,0x22,0x33,0x44, and `bubble` never 1.
- WAIT=2; pc=8, word 2=0xDEADBEEF -> `bubble`=1,1,0 for cycles c0..c2, then `instr`=0xDEADBEEF with `instr_valid`=1 in c3; the next request at pc=12 is accepted in c3.
- WAIT=2; pc=6 and pc=4*DEPTH -> each gives `instr_valid`=1, `fault`=1, `instr`=0x00000013 one cycle after the request, with `bubble`=0.
- WAIT=3; `flush` in the second wait cycle -> `bubble`=0 that cycle, no `instr_valid` pulse, and the next request behaves normally.
- WAIT=3; `rst` asserted low in the middle of a wait -> `bubble`=0 immediately, then `instr_valid`=0 and `instr`=0x00000013 until a new request completes after release.
- WAIT=0; `ld_en` writes word 5=0xAAAA0000 in the same edge as a fetch of pc=20 (old value 0x5555) -> the response is 0x5555; the refetch of pc=20 returns 0xAAAA0000.

Source files
------------

// File: rtl/riscv_imem_resp_if.sv
// Fetch-side bus between the RISC-V fetch stage (master) and the instruction-memory responder (slave).
// Latency: none, this is wiring only; the responder defines all timing.
// Backpressure: the responder drives bubble, which holds the fetch stage's PC.
interface riscv_imem_resp_if;
  logic        req;
  logic [31:0] pc;
  logic        flush;
  logic        bubble;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault;

  modport master (
    output req, pc, flush,
    input  bubble, instr, instr_valid, fault
  );

  modport slave (
    input  req, pc, flush,
    output bubble, instr, instr_valid, fault
  );
endinterface

// File: rtl/riscv_imem_resp.sv
// Instruction-memory responder: answers fetch PCs from a word array loaded through a side port.
// Latency: WAIT+1 cycles from an accepted request to instr_valid; bad PCs answer in 1 cycle.
// Backpressure: combinational bubble holds the fetch PC while wait states count down.
module riscv_imem_resp #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  riscv_imem_resp_if.slave bus,
  input  logic             ld_en,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data
);

  localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U     = 32'(DEPTH);
  localparam logic [2:0]  WAIT_RELOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef enum logic {
    IDLE    = 1'b0,
    WAITING = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          fault_q, fault_d;
  logic          bubble_c;

  // Instruction storage; deliberately not reset, the loader owns its contents.
  logic [31:0]   mem [DEPTH];

  logic          req_bad;
  logic          accept;
  logic          ld_hit;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

  // Request decode: misaligned PCs and PCs past the array end are answered with a fault.
  always_comb begin
    req_bad = (bus.pc[1:0] != 2'b00) || ({2'b00, bus.pc[31:2]} >= DEPTH_U);
    accept  = (state_q == IDLE) && bus.req && !bus.flush;
    req_idx = bus.pc[AW+1:2];
    ld_hit  = ld_en && (ld_addr < DEPTH_U);
    // A waiting fetch reads the captured word index, a fresh one reads the live PC.
    rd_idx  = (state_q == WAITING) ? addr_q : req_idx;
    rd_word = mem[rd_idx];
  end

  // Array write port; the read above sees the old word on a same-edge collision.
  always_ff @(posedge clk) begin
    if (ld_hit) begin
      mem[ld_addr[AW-1:0]] <= ld_data;
    end
  end

  // Next-state, response and stall logic for the IDLE/WAITING controller.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fault_d       = 1'b0;
    bubble_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad) begin
            // Faulting fetches never pay wait states and carry a NOP.
            instr_d       = NOP;
            instr_valid_d = 1'b1;
            fault_d       = 1'b1;
          end else if (WAIT == 0) begin
            instr_d       = rd_word;
            instr_valid_d = 1'b1;
          end else begin
            // Hold the PC for the wait states; the first wait cycle is this one.
            bubble_c = 1'b1;
            addr_d   = req_idx;
            cnt_d    = WAIT_RELOAD;
            state_d  = WAITING;
          end
        end
      end

      WAITING: begin
        if (bus.flush) begin
          // Abandon the fetch silently; the fetch stage is redirecting.
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          // Last cycle: release the PC and present the word next cycle.
          instr_d       = rd_word;
          instr_valid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          bubble_c = 1'b1;
          cnt_d    = cnt_q - 3'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Controller and response registers; reset drops any pending fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      addr_q        <= '0;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  // The stall is forced low while reset is held so the fetch stage is never frozen by it.
  assign bus.bubble      = rst & bubble_c;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_riscv_imem_resp.sv
// Bench for riscv_imem_resp: three instances (WAIT=0,2,3) share one stimulus stream.
// Latency: expectations are queued at request time and matched on instr_valid.
// Backpressure: the bench holds req/pc while bubble is expected, like a real fetch stage.
module tb_riscv_imem_resp;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  typedef struct packed {
    logic        r;
    logic [31:0] p;
    logic        f;
    logic        eb;
    logic        ev;
    logic        push;
    logic [31:0] pi;
    logic        pf;
    logic        le;
    logic [31:0] la;
    logic [31:0] ldd;
  } row_t;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        req     = 1'b0;
  logic        flush   = 1'b0;
  logic [31:0] pc      = 32'd0;
  logic        ld_en   = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic [31:0] ld_data = 32'd0;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  // Index 0: WAIT=0, index 1: WAIT=2, index 2: WAIT=3.
  logic        bub [3];
  logic        vld [3];
  logic        flt [3];
  logic [31:0] ins [3];

  riscv_imem_resp_if if0();
  riscv_imem_resp_if if2();
  riscv_imem_resp_if if3();

  assign if0.req = req;  assign if0.pc = pc;  assign if0.flush = flush;
  assign if2.req = req;  assign if2.pc = pc;  assign if2.flush = flush;
  assign if3.req = req;  assign if3.pc = pc;  assign if3.flush = flush;

  assign bub[0] = if0.bubble;  assign vld[0] = if0.instr_valid;
  assign flt[0] = if0.fault;   assign ins[0] = if0.instr;
  assign bub[1] = if2.bubble;  assign vld[1] = if2.instr_valid;
  assign flt[1] = if2.fault;   assign ins[1] = if2.instr;
  assign bub[2] = if3.bubble;  assign vld[2] = if3.instr_valid;
  assign flt[2] = if3.fault;   assign ins[2] = if3.instr;

  riscv_imem_resp #(.DEPTH(DEPTH), .WAIT(0)) dut_w0 (
    .clk(clk), .rst(rst), .bus(if0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  riscv_imem_resp #(.DEPTH(DEPTH), .WAIT(2)) dut_w2 (
    .clk(clk), .rst(rst), .bus(if2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  riscv_imem_resp #(.DEPTH(DEPTH), .WAIT(3)) dut_w3 (
    .clk(clk), .rst(rst), .bus(if3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  function automatic row_t mk(input logic r, input logic [31:0] p, input logic f,
                              input logic eb, input logic ev, input logic push,
                              input logic [31:0] pi, input logic pf,
                              input logic le = 1'b0, input logic [31:0] la = 32'd0,
                              input logic [31:0] ldd = 32'd0);
    row_t x;
    x.r = r;  x.p = p;  x.f = f;  x.eb = eb;  x.ev = ev;
    x.push = push;  x.pi = pi;  x.pf = pf;
    x.le = le;  x.la = la;  x.ldd = ldd;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; pc = 32'd0; flush = 1'b0; ld_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    step();
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b1; pc = 32'd8; flush = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (bub[k] !== 1'b0) begin fails++; $display("FAIL reset bubble dut%0d: got %b expected 0", k, bub[k]); end
        tests++;
        if (vld[k] !== 1'b0) begin fails++; $display("FAIL reset instr_valid dut%0d: got %b expected 0", k, vld[k]); end
        tests++;
        if (flt[k] !== 1'b0) begin fails++; $display("FAIL reset fault dut%0d: got %b expected 0", k, flt[k]); end
        tests++;
        if (ins[k] !== NOP) begin fails++; $display("FAIL reset instr dut%0d: got %h expected %h", k, ins[k], NOP); end
      end
      step();
    end
    rst = 1'b1; req = 1'b0; pc = 32'd0;
  endtask

  task automatic test_stream_w0();
    row_t rows[$];
    exp_t e;
    load_word(32'd0, 32'h11); load_word(32'd1, 32'h22);
    load_word(32'd2, 32'h33); load_word(32'd3, 32'h44);
    idle(2);
    exp_q.delete();
    rows.push_back(mk(1, 32'd0,  0, 0, 0, 1, 32'h11, 0));
    rows.push_back(mk(1, 32'd4,  0, 0, 1, 1, 32'h22, 0));
    rows.push_back(mk(1, 32'd8,  0, 0, 1, 1, 32'h33, 0));
    rows.push_back(mk(1, 32'd12, 0, 0, 1, 1, 32'h44, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 1, 0, 32'h0,  0));
    rows.push_back(mk(0, 32'd0,  0, 0, 0, 0, 32'h0,  0));
    foreach (rows[i]) begin
      step();
      req = rows[i].r; pc = rows[i].p; flush = rows[i].f;
      ld_en = rows[i].le; ld_addr = rows[i].la; ld_data = rows[i].ldd;
      if (rows[i].push) begin e.instr = rows[i].pi; e.fault = rows[i].pf; exp_q.push_back(e); end
      @(negedge clk);
      tests++;
      if (bub[0] !== rows[i].eb) begin fails++; $display("FAIL stream bubble cyc %0d: got %b expected %b", i, bub[0], rows[i].eb); end
      tests++;
      if (vld[0] !== rows[i].ev) begin fails++; $display("FAIL stream instr_valid cyc %0d: got %b expected %b", i, vld[0], rows[i].ev); end
      if (vld[0] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL stream response cyc %0d: got %h with no expected response queued", i, ins[0]);
        end else begin
          e = exp_q.pop_front();
          if (ins[0] !== e.instr || flt[0] !== e.fault) begin
            fails++; $display("FAIL stream data cyc %0d: got %h/%b expected %h/%b", i, ins[0], flt[0], e.instr, e.fault);
          end
        end
      end
    end
    idle(1);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL stream leftover: %0d responses missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_wait2();
    row_t rows[$];
    exp_t e;
    load_word(32'd2, 32'hDEAD_BEEF); load_word(32'd3, 32'h1234_5678);
    idle(6);
    exp_q.delete();
    rows.push_back(mk(1, 32'd8,  0, 1, 0, 1, 32'hDEAD_BEEF, 0));
    rows.push_back(mk(1, 32'd8,  0, 1, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd8,  0, 0, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd12, 0, 1, 1, 1, 32'h1234_5678, 0));
    rows.push_back(mk(1, 32'd12, 0, 1, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd12, 0, 0, 0, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 1, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 0, 0, 32'h0, 0));
    foreach (rows[i]) begin
      step();
      req = rows[i].r; pc = rows[i].p; flush = rows[i].f;
      ld_en = rows[i].le; ld_addr = rows[i].la; ld_data = rows[i].ldd;
      if (rows[i].push) begin e.instr = rows[i].pi; e.fault = rows[i].pf; exp_q.push_back(e); end
      @(negedge clk);
      tests++;
      if (bub[1] !== rows[i].eb) begin fails++; $display("FAIL wait2 bubble cyc %0d: got %b expected %b", i, bub[1], rows[i].eb); end
      tests++;
      if (vld[1] !== rows[i].ev) begin fails++; $display("FAIL wait2 instr_valid cyc %0d: got %b expected %b", i, vld[1], rows[i].ev); end
      if (vld[1] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL wait2 response cyc %0d: got %h with no expected response queued", i, ins[1]);
        end else begin
          e = exp_q.pop_front();
          if (ins[1] !== e.instr || flt[1] !== e.fault) begin
            fails++; $display("FAIL wait2 data cyc %0d: got %h/%b expected %h/%b", i, ins[1], flt[1], e.instr, e.fault);
          end
        end
      end
    end
    idle(1);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL wait2 leftover: %0d responses missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_fault();
    row_t rows[$];
    exp_t e;
    idle(6);
    exp_q.delete();
    rows.push_back(mk(1, 32'd6,       0, 0, 0, 1, NOP, 1));
    rows.push_back(mk(1, 32'd4*DEPTH, 0, 0, 1, 1, NOP, 1));
    rows.push_back(mk(0, 32'd0,       0, 0, 1, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,       0, 0, 0, 0, 32'h0, 0));
    foreach (rows[i]) begin
      step();
      req = rows[i].r; pc = rows[i].p; flush = rows[i].f;
      ld_en = rows[i].le; ld_addr = rows[i].la; ld_data = rows[i].ldd;
      if (rows[i].push) begin e.instr = rows[i].pi; e.fault = rows[i].pf; exp_q.push_back(e); end
      @(negedge clk);
      tests++;
      if (bub[1] !== rows[i].eb) begin fails++; $display("FAIL fault bubble cyc %0d: got %b expected %b", i, bub[1], rows[i].eb); end
      tests++;
      if (vld[1] !== rows[i].ev) begin fails++; $display("FAIL fault instr_valid cyc %0d: got %b expected %b", i, vld[1], rows[i].ev); end
      tests++;
      if (flt[1] !== rows[i].ev) begin fails++; $display("FAIL fault pulse cyc %0d: got %b expected %b", i, flt[1], rows[i].ev); end
      if (vld[1] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL fault response cyc %0d: got %h with no expected response queued", i, ins[1]);
        end else begin
          e = exp_q.pop_front();
          if (ins[1] !== e.instr || flt[1] !== e.fault) begin
            fails++; $display("FAIL fault data cyc %0d: got %h/%b expected %h/%b", i, ins[1], flt[1], e.instr, e.fault);
          end
        end
      end
    end
    idle(1);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL fault leftover: %0d responses missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    row_t rows[$];
    exp_t e;
    load_word(32'd7, 32'hCAFE_0007);
    idle(6);
    exp_q.delete();
    rows.push_back(mk(1, 32'd28, 0, 1, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd28, 1, 0, 0, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 0, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 0, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd28, 0, 1, 0, 1, 32'hCAFE_0007, 0));
    rows.push_back(mk(1, 32'd28, 0, 1, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd28, 0, 1, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd28, 0, 0, 0, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 1, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 0, 0, 32'h0, 0));
    foreach (rows[i]) begin
      step();
      req = rows[i].r; pc = rows[i].p; flush = rows[i].f;
      ld_en = rows[i].le; ld_addr = rows[i].la; ld_data = rows[i].ldd;
      if (rows[i].push) begin e.instr = rows[i].pi; e.fault = rows[i].pf; exp_q.push_back(e); end
      @(negedge clk);
      tests++;
      if (bub[2] !== rows[i].eb) begin fails++; $display("FAIL flush bubble cyc %0d: got %b expected %b", i, bub[2], rows[i].eb); end
      tests++;
      if (vld[2] !== rows[i].ev) begin fails++; $display("FAIL flush instr_valid cyc %0d: got %b expected %b", i, vld[2], rows[i].ev); end
      if (vld[2] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL flush response cyc %0d: got %h with no expected response queued", i, ins[2]);
        end else begin
          e = exp_q.pop_front();
          if (ins[2] !== e.instr || flt[2] !== e.fault) begin
            fails++; $display("FAIL flush data cyc %0d: got %h/%b expected %h/%b", i, ins[2], flt[2], e.instr, e.fault);
          end
        end
      end
    end
    idle(1);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL flush leftover: %0d responses missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    exp_t e;
    idle(6);
    exp_q.delete();
    step();
    req = 1'b1; pc = 32'd28;
    @(negedge clk);
    tests++;
    if (bub[2] !== 1'b1) begin fails++; $display("FAIL rstmid bubble c0: got %b expected 1", bub[2]); end
    step();
    @(negedge clk);
    tests++;
    if (bub[2] !== 1'b1) begin fails++; $display("FAIL rstmid bubble c1: got %b expected 1", bub[2]); end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bub[2] !== 1'b0) begin fails++; $display("FAIL rstmid bubble at reset: got %b expected 0", bub[2]); end
    tests++;
    if (vld[2] !== 1'b0) begin fails++; $display("FAIL rstmid instr_valid at reset: got %b expected 0", vld[2]); end
    tests++;
    if (ins[2] !== NOP) begin fails++; $display("FAIL rstmid instr at reset: got %h expected %h", ins[2], NOP); end
    step();
    @(negedge clk);
    tests++;
    if (bub[2] !== 1'b0) begin fails++; $display("FAIL rstmid bubble in reset: got %b expected 0", bub[2]); end
    step();
    rst = 1'b1; req = 1'b0; pc = 32'd0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      tests++;
      if (vld[2] !== 1'b0 || bub[2] !== 1'b0) begin
        fails++; $display("FAIL rstmid after release cyc %0d: valid/bubble got %b/%b expected 0/0", n, vld[2], bub[2]);
      end
      tests++;
      if (ins[2] !== NOP) begin fails++; $display("FAIL rstmid instr after release cyc %0d: got %h expected %h", n, ins[2], NOP); end
      step();
    end
    rows.push_back(mk(1, 32'd28, 0, 1, 0, 1, 32'hCAFE_0007, 0));
    rows.push_back(mk(1, 32'd28, 0, 1, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd28, 0, 1, 0, 0, 32'h0, 0));
    rows.push_back(mk(1, 32'd28, 0, 0, 0, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 1, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 0, 0, 32'h0, 0));
    foreach (rows[i]) begin
      if (i != 0) step();
      req = rows[i].r; pc = rows[i].p; flush = rows[i].f;
      ld_en = rows[i].le; ld_addr = rows[i].la; ld_data = rows[i].ldd;
      if (rows[i].push) begin e.instr = rows[i].pi; e.fault = rows[i].pf; exp_q.push_back(e); end
      @(negedge clk);
      tests++;
      if (bub[2] !== rows[i].eb) begin fails++; $display("FAIL rstmid refetch bubble cyc %0d: got %b expected %b", i, bub[2], rows[i].eb); end
      tests++;
      if (vld[2] !== rows[i].ev) begin fails++; $display("FAIL rstmid refetch instr_valid cyc %0d: got %b expected %b", i, vld[2], rows[i].ev); end
      if (vld[2] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rstmid response cyc %0d: got %h with no expected response queued", i, ins[2]);
        end else begin
          e = exp_q.pop_front();
          if (ins[2] !== e.instr || flt[2] !== e.fault) begin
            fails++; $display("FAIL rstmid data cyc %0d: got %h/%b expected %h/%b", i, ins[2], flt[2], e.instr, e.fault);
          end
        end
      end
    end
    idle(1);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL rstmid leftover: %0d responses missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_collision();
    row_t rows[$];
    exp_t e;
    load_word(32'd5, 32'h0000_5555);
    idle(6);
    exp_q.delete();
    rows.push_back(mk(1, 32'd20, 0, 0, 0, 1, 32'h0000_5555, 0, 1, 32'd5, 32'hAAAA_0000));
    rows.push_back(mk(1, 32'd20, 0, 0, 1, 1, 32'hAAAA_0000, 0, 1, 32'd261, 32'hBADB_AD01));
    rows.push_back(mk(1, 32'd20, 0, 0, 1, 1, 32'hAAAA_0000, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 1, 0, 32'h0, 0));
    rows.push_back(mk(0, 32'd0,  0, 0, 0, 0, 32'h0, 0));
    foreach (rows[i]) begin
      step();
      req = rows[i].r; pc = rows[i].p; flush = rows[i].f;
      ld_en = rows[i].le; ld_addr = rows[i].la; ld_data = rows[i].ldd;
      if (rows[i].push) begin e.instr = rows[i].pi; e.fault = rows[i].pf; exp_q.push_back(e); end
      @(negedge clk);
      tests++;
      if (bub[0] !== rows[i].eb) begin fails++; $display("FAIL collide bubble cyc %0d: got %b expected %b", i, bub[0], rows[i].eb); end
      tests++;
      if (vld[0] !== rows[i].ev) begin fails++; $display("FAIL collide instr_valid cyc %0d: got %b expected %b", i, vld[0], rows[i].ev); end
      if (vld[0] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL collide response cyc %0d: got %h with no expected response queued", i, ins[0]);
        end else begin
          e = exp_q.pop_front();
          if (ins[0] !== e.instr || flt[0] !== e.fault) begin
            fails++; $display("FAIL collide data cyc %0d: got %h/%b expected %h/%b", i, ins[0], flt[0], e.instr, e.fault);
          end
        end
      end
    end
    idle(1);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL collide leftover: %0d responses missing, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream_w0();
    test_wait2();
    test_fault();
    test_flush();
    test_reset_mid();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
